// File: rtl/dsp38_mult_arbiter.sv
// Round-robin arbiter sharing one 20x18 multiplier among NUM_REQ requesters.
// Optional per-requester grant counters when DSP38_ARB_STATS_EN is defined.
module dsp38_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [20*NUM_REQ-1:0]  req_a,
  input  logic [18*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_unsigned_a,
  input  logic [NUM_REQ-1:0]     req_unsigned_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [37:0]            resp_z,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
`ifdef DSP38_ARB_STATS_EN
  ,
  input  logic [ID_W-1:0]        stat_sel,
  output logic [15:0]            stat_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] pend_id;
  logic            found;
  logic            grant;

  logic [19:0] op_a, sel_a;
  logic [17:0] op_b, sel_b;
  logic        op_ua, op_ub;
  logic        sel_ua, sel_ub;

  logic [37:0] ext_a, ext_b, dsp_z;

  // Two passes: indices at/after rr_ptr first, then wrap to 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && ID_W'(i) >= rr_ptr) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end

  assign grant = (state == IDLE) && found;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_ua    = 1'b0;
    sel_ub    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        req_ready[i] = grant;
        sel_a        = req_a[20*i +: 20];
        sel_b        = req_b[18*i +: 18];
        sel_ua       = req_unsigned_a[i];
        sel_ub       = req_unsigned_b[i];
      end
    end
  end

  // Extending both operands to 38 bits keeps the low 38 product bits exact
  // for every signedness mix, since the true product always fits.
  assign ext_a = {{18{~op_ua & op_a[19]}}, op_a};
  assign ext_b = {{20{~op_ub & op_b[17]}}, op_b};
  assign dsp_z = ext_a * ext_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: if (grant) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      pend_id    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_ua      <= 1'b0;
      op_ub      <= 1'b0;
      resp_valid <= 1'b0;
      resp_z     <= '0;
      resp_id    <= '0;
    end else begin
      if (grant) begin
        op_a    <= sel_a;
        op_b    <= sel_b;
        op_ua   <= sel_ua;
        op_ub   <= sel_ub;
        pend_id <= winner;
        rr_ptr  <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (state == EXEC) begin
        resp_z     <= dsp_z;
        resp_id    <= pend_id;
        resp_valid <= 1'b1;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifdef DSP38_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant && winner == ID_W'(i) && stat_cnt[i] != 16'hFFFF)
          stat_cnt[i] <= stat_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stat_sel == ID_W'(i)) stat_count = stat_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_dsp38_mult_arbiter.sv
// Directed bench for dsp38_mult_arbiter: vector table plus corner sequences.
// Stats checks are included when DSP38_ARB_STATS_EN is defined.
module tb_dsp38_mult_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [20*N-1:0]   req_a;
  logic [18*N-1:0]   req_b;
  logic [N-1:0]      req_unsigned_a;
  logic [N-1:0]      req_unsigned_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [37:0]       resp_z;
  logic [IW-1:0]     resp_id;
  logic              busy;
`ifdef DSP38_ARB_STATS_EN
  logic [IW-1:0]     stat_sel;
  logic [15:0]       stat_count;
`endif

  dsp38_mult_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_unsigned_a (req_unsigned_a),
    .req_unsigned_b (req_unsigned_b),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_z         (resp_z),
    .resp_id        (resp_id),
    .busy           (busy)
`ifdef DSP38_ARB_STATS_EN
    ,
    .stat_sel       (stat_sel),
    .stat_count     (stat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [19:0] a;
    logic [17:0] b;
    logic        ua;
    logic        ub;
    logic [37:0] z;
  } vec_t;

  vec_t vecs[7];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic set_op(input int idx, input logic [19:0] a,
                        input logic [17:0] b, input logic ua,
                        input logic ub);
    req_a[20*idx +: 20]  = a;
    req_b[18*idx +: 18]  = b;
    req_unsigned_a[idx] = ua;
    req_unsigned_b[idx] = ub;
  endtask

  // Single op with resp_ready high: accept, EXEC, response, back to IDLE.
  task automatic do_op(input string tag, input int idx,
                       input logic [19:0] a, input logic [17:0] b,
                       input logic ua, input logic ub,
                       input logic [37:0] z);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    set_op(idx, a, b, ua, ub);
    resp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(1) << idx);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    tick();
    req_valid = '0;
    req_a = ~req_a;
    req_b = ~req_b;
    req_unsigned_a = ~req_unsigned_a;
    req_unsigned_b = ~req_unsigned_b;
    #1;
    check({tag, "_exec_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_exec_busy"}, 64'(busy), 64'd1);
    tick();
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
    check({tag, "_resp_z"}, 64'(resp_z), 64'(z));
    check({tag, "_resp_id"}, 64'(resp_id), 64'(idx));
    tick();
    check({tag, "_done_valid"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int got;
    int cyc;

    vecs[0] = '{0, 20'hFFFFD, 18'd5,      1'b0, 1'b0, 38'h3F_FFFF_FFF1};
    vecs[1] = '{2, 20'hFFFFF, 18'h3FFFF,  1'b1, 1'b1, 38'h3F_FFEC_0001};
    vecs[2] = '{1, 20'd1000,  18'd3000,   1'b0, 1'b0, 38'h00_002D_C6C0};
    vecs[3] = '{3, 20'h80000, 18'h1FFFF,  1'b0, 1'b0, 38'h30_0008_0000};
    vecs[4] = '{0, 20'hFFFFF, 18'h3FFFF,  1'b0, 1'b1, 38'h3F_FFFC_0001};
    vecs[5] = '{1, 20'hFFFFF, 18'h3FFFF,  1'b1, 1'b0, 38'h3F_FFF0_0001};
    vecs[6] = '{2, 20'h80000, 18'h20000,  1'b0, 1'b0, 38'h10_0000_0000};

    reset_n        = 1'b0;
    req_valid      = '0;
    req_a          = '0;
    req_b          = '0;
    req_unsigned_a = '0;
    req_unsigned_b = '0;
    resp_ready     = 1'b1;
`ifdef DSP38_ARB_STATS_EN
    stat_sel = '0;
`endif
    #3;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_z", 64'(resp_z), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      do_op($sformatf("vec%0d", v), vecs[v].idx, vecs[v].a, vecs[v].b,
            vecs[v].ua, vecs[v].ub, vecs[v].z);
    end

    // Round robin with all requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 20'(i + 1), 18'd10, 1'b0, 1'b0);
    resp_ready = 1'b1;
    req_valid  = '1;
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 200) begin
      check("rr_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (resp_valid) begin
        check($sformatf("rr_id%0d", got), 64'(resp_id), 64'(got % 4));
        check($sformatf("rr_z%0d", got), 64'(resp_z),
              64'(((got % 4) + 1) * 10));
        got++;
      end
      tick();
      cyc++;
    end
    if (got < 8) check("rr_timeout", 64'(got), 64'd8);
    req_valid = '0;

    // Backpressure: rr_ptr is back at 0 after eight grants.
    set_op(0, 20'd7, 18'd6, 1'b0, 1'b0);
    set_op(1, 20'd2, 18'd3, 1'b0, 1'b0);
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    #1;
    check("bp_grant0", 64'(req_ready), 64'd1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid%0d", c), 64'(resp_valid), 64'd1);
      check($sformatf("bp_z%0d", c), 64'(resp_z), 64'd42);
      check($sformatf("bp_id%0d", c), 64'(resp_id), 64'd0);
      check($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_hs_valid", 64'(resp_valid), 64'd1);
    tick();
    check("bp_after_valid", 64'(resp_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    tick();
    check("bp_op2_valid", 64'(resp_valid), 64'd1);
    check("bp_op2_z", 64'(resp_z), 64'd6);
    check("bp_op2_id", 64'(resp_id), 64'd1);
    tick();

    // Reset during EXEC; rr_ptr would otherwise point at 2.
    set_op(1, 20'd9, 18'd9, 1'b0, 1'b0);
    req_valid = 4'b0010;
    #1;
    check("rm_grant1", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    reset_n   = 1'b0;
    tick();
    check("rm_valid", 64'(resp_valid), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    check("rm_z", 64'(resp_z), 64'd0);
    check("rm_id", 64'(resp_id), 64'd0);
    reset_n = 1'b1;
    set_op(0, 20'd4, 18'd4, 1'b0, 1'b0);
    set_op(2, 20'd5, 18'd5, 1'b0, 1'b0);
    req_valid = 4'b0101;
    #1;
    check("rm_prio0", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    tick();
    check("rm_op_valid", 64'(resp_valid), 64'd1);
    check("rm_op_z", 64'(resp_z), 64'd16);
    check("rm_op_id", 64'(resp_id), 64'd0);
    tick();

`ifdef DSP38_ARB_STATS_EN
    do_reset();
    do_op("st_a", 1, 20'd1, 18'd1, 1'b0, 1'b0, 38'd1);
    do_op("st_b", 1, 20'd2, 18'd2, 1'b0, 1'b0, 38'd4);
    do_op("st_c", 3, 20'd3, 18'd3, 1'b0, 1'b0, 38'd9);
    do_op("st_d", 1, 20'd4, 18'd4, 1'b0, 1'b0, 38'd16);
    stat_sel = 2'd1;
    #1;
    check("stat1", 64'(stat_count), 64'd3);
    stat_sel = 2'd3;
    #1;
    check("stat3", 64'(stat_count), 64'd1);
    stat_sel = 2'd0;
    #1;
    check("stat0", 64'(stat_count), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dsp38_mult_arbiter.md
Name: dsp38_mult_arbiter

Overview:
Shares one DSP38 multiplier between NUM_REQ independent requesters using round-robin arbitration. The DSP38 is configured as DSP_MODE "MULTIPLY" with input and output registers disabled, and FEEDBACK is tied to 3'b000. Operand capture, the result register and the response handshake are handled by this block's own FSM. It sits between requester datapaths (filters, address generators) and the single DSP38 site reserved for them.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, width of resp_id; must be >= clog2(NUM_REQ).

Ports:
clk  input  1  single clock; all state is rising-edge.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
req_a  input  20*NUM_REQ  packed A operands; requester i uses bits [20*i+19:20*i].
req_b  input  18*NUM_REQ  packed B operands; requester i uses bits [18*i+17:18*i].
req_unsigned_a  input  NUM_REQ  per-requester UNSIGNED_A flag.
req_unsigned_b  input  NUM_REQ  per-requester UNSIGNED_B flag.
resp_valid  output  1  result available.
resp_ready  input  1  consumer accepts the result.
resp_z  output  38  product.
resp_id  output  ID_W  index of the requester that owns resp_z.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release) sets these values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_z=0, resp_id=0, busy=0.
  - Operand registers are cleared to 0.
- FSM states and transitions:
  - IDLE: the winner is the first i with req_valid[i]=1, searching circularly from rr_ptr. req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits stay 0.
  - On that handshake: capture req_a/req_b/unsigned flags of the winner into the operand registers, set rr_ptr = (winner+1) mod NUM_REQ, latch the winner as the pending id, and move to EXEC. With no valid request, stay in IDLE.
  - EXEC: the DSP38 computes from the operand registers. At the clock edge, resp_z <= DSP Z, resp_id <= pending id, resp_valid <= 1, and the FSM moves to RESP.
  - RESP: resp_valid, resp_z and resp_id are held stable until resp_ready=1. On that handshake resp_valid clears and the FSM returns to IDLE.
- req_ready is 0 in EXEC and RESP; only one operation is outstanding at a time.
- Latency: request accept in cycle T gives resp_valid=1 in cycle T+2. Peak throughput is one operation per 3 cycles; the new grant can occur in the cycle after the response handshake.
- Arithmetic: Z is the full-precision 20x18 product, signed or unsigned per captured flag, in 38 bits with no truncation or saturation.
  - Mixed signedness is allowed and is passed straight to the DSP38.
- Boundary conditions:
  - A requester deasserting req_valid before it is granted is legal and leaves no side effect.
  - Operands are sampled only on the handshake cycle.
  - When rr_ptr points to a non-requesting index, the search wraps past NUM_REQ-1 to 0.
  - All requesters valid continuously: grants are served strictly in order rr_ptr, rr_ptr+1, …
  - resp_ready held high permanently: the RESP state lasts exactly one cycle.
  - reset_n asserted mid-EXEC or mid-RESP: the in-flight result is discarded, no response is emitted, and rr_ptr returns to 0.

Optional Feature:
DSP38_ARB_STATS_EN:
- Defined: adds ports stat_sel (input, ID_W) and stat_count (output, 16). Each requester has a 16-bit grant counter that increments on its IDLE handshake and saturates at 16'hFFFF. stat_count = counter[stat_sel] combinationally. Counters reset to 0 on reset_n.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Single signed op: req0 with a=20'hFFFFD (-3), b=18'd5, both flags 0, resp_ready=1. Required: resp_valid exactly 2 cycles after accept, resp_z=38'h3F_FFFF_FFF1, resp_id=0.
2. Unsigned corner: req2 with a=20'hFFFFF, b=18'h3FFFF, both flags 1. Required: resp_z=38'h3F_FFEC_0001, resp_id=2.
3. Round-robin fairness: all four req_valid held high, resp_ready=1, 8 operations. Required: resp_id sequence 0,1,2,3,0,1,2,3, with req_ready never multi-hot.
4. Backpressure: resp_ready=0 for 5 cycles after resp_valid, then 1. Required: resp_z/resp_id stable throughout, req_ready=0 throughout, new grant in the cycle after the handshake.
5. Reset mid-op: assert reset_n=0 during EXEC. Required: next cycle resp_valid=0, busy=0, resp_z=0; after release, requester 0 has priority.
6. With DSP38_ARB_STATS_EN: 3 ops from req1 and 1 from req3. Required: stat_count = 3 for stat_sel=1, 1 for stat_sel=3, 0 for stat_sel=0.
